// File: rtl/pc_fetch_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package pc_fetch_pkg;

  localparam int unsigned DEF_STEP      = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory port plus decode-side presentation handshake.
interface pc_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              stall;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, stall
  );
endinterface

// File: rtl/pc_next_reg.sv
// Program counter register: aligned redirect load takes priority over increment.
module pc_next_reg #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt
);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STEP - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc & ALIGN_MASK;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  assign pc     = pc_q;
  assign pc_nxt = pc_d;
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch FSM: requests words at the PC, presents them to decode and applies redirects.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 redirect,
  input  logic [ADDR_W-1:0]    redirect_pc,
  output logic [ADDR_W-1:0]    pc,
  pc_fetch_sequencer_if.master bus
);
  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              pc_load, pc_inc;
  logic [ADDR_W-1:0] pc_nxt;

  pc_next_reg #(
    .ADDR_W    (ADDR_W),
    .STEP      (STEP),
    .RESET_VEC (RESET_VEC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc),
    .pc_nxt  (pc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d     = FETCH;
          imem_addr_d = pc_nxt;
        end
      end
      FETCH: begin
        pc_load = redirect;
        if (bus.imem_ack) begin
          if (kill_q || redirect) begin
            // Stale data: drop it and restart at the (possibly just redirected) pc.
            kill_d      = 1'b0;
            state_d     = run ? FETCH : IDLE;
            imem_addr_d = pc_nxt;
          end else begin
            instr_d    = bus.imem_rdata;
            instr_pc_d = pc;
            state_d    = ISSUE;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      ISSUE: begin
        if (redirect) begin
          pc_load     = 1'b1;
          state_d     = FETCH;
          imem_addr_d = pc_nxt;
        end else if (!bus.stall) begin
          pc_inc      = 1'b1;
          state_d     = run ? FETCH : IDLE;
          imem_addr_d = pc_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_VEC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: memory words pushed on ack, checked on presentation.
module tb_pc_fetch_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, redirect;
  logic [31:0] redirect_pc, pc;
  logic        run_w, redirect_w;
  logic [31:0] redirect_pc_w, pc_w;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        sb_q[$];
  logic        valid_prev = 1'b0;

  pc_fetch_sequencer_if #(.ADDR_W(32)) bus ();
  pc_fetch_sequencer_if #(.ADDR_W(32)) bus_w ();

  pc_fetch_sequencer #(.ADDR_W(32), .STEP(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .bus         (bus)
  );

  pc_fetch_sequencer #(.ADDR_W(32), .STEP(4), .RESET_VEC(32'hFFFF_FFFC)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w),
    .pc          (pc_w),
    .bus         (bus_w)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expects an outstanding request at exp_addr, acks it for one cycle, optionally scoreboards it.
  task automatic fetch_ack(input logic [31:0] exp_addr, input bit keep);
    exp_t e;
    check("req", 64'(bus.imem_req), 64'd1);
    check("addr", 64'(bus.imem_addr), 64'(exp_addr));
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word_of(exp_addr);
    if (keep) begin
      e.pc    = exp_addr;
      e.instr = word_of(exp_addr);
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
  endtask

  always @(negedge clk) begin
    if (bus.instr_valid && !valid_prev) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("instr", 64'(bus.instr), 64'(e.instr));
        check("instr_pc", 64'(bus.instr_pc), 64'(e.pc));
      end
    end
    valid_prev = bus.instr_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0;
    run_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.stall = 1'b0;
    bus_w.imem_ack = 1'b0; bus_w.imem_rdata = '0; bus_w.stall = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_w_pc", 64'(pc_w), 64'hFFFF_FFFC);
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);

    // Zero-wait sequential fetches at 0, 4, 8.
    for (int unsigned i = 0; i < 3; i++) begin
      fetch_ack(32'(i * 4), 1'b1);
      check("seq_valid", 64'(bus.instr_valid), 64'd1);
      check("seq_req", 64'(bus.imem_req), 64'd0);
      if (i < 2) @(negedge clk);
    end

    // Stall for three cycles while presenting the instruction at 8.
    bus.stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      check("stall_valid", 64'(bus.instr_valid), 64'd1);
      check("stall_instr", 64'(bus.instr), 64'(word_of(32'd8)));
      check("stall_ipc", 64'(bus.instr_pc), 64'd8);
      check("stall_req", 64'(bus.imem_req), 64'd0);
      check("stall_pc", 64'(pc), 64'd8);
      @(negedge clk);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    fetch_ack(32'd12, 1'b1);
    @(negedge clk);

    // Redirect while the fetch at 16 waits two cycles for its ack.
    check("wait_addr", 64'(bus.imem_addr), 64'd16);
    redirect = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    redirect = 1'b0;
    check("kill_addr_hold", 64'(bus.imem_addr), 64'd16);
    check("kill_pc", 64'(pc), 64'h100);
    fetch_ack(32'd16, 1'b0);
    check("kill_valid", 64'(bus.instr_valid), 64'd0);
    fetch_ack(32'h100, 1'b1);
    check("redir_issue_valid", 64'(bus.instr_valid), 64'd1);

    // Redirect in ISSUE with stall low: drop instruction, fetch target.
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("drop_valid", 64'(bus.instr_valid), 64'd0);
    check("drop_pc", 64'(pc), 64'h40);
    fetch_ack(32'h40, 1'b1);

    // run low at consume point parks in IDLE; ack there is ignored.
    run = 1'b0;
    @(negedge clk);
    check("idle_req", 64'(bus.imem_req), 64'd0);
    check("idle_pc", 64'(pc), 64'h44);
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("idle_ack_req", 64'(bus.imem_req), 64'd0);
    check("idle_ack_valid", 64'(bus.instr_valid), 64'd0);

    // Reset in the middle of an unacknowledged fetch.
    run = 1'b1;
    @(negedge clk);
    check("pre_rst_addr", 64'(bus.imem_addr), 64'h44);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 64'(bus.imem_req), 64'd0);
    check("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
    check("mid_rst_instr", 64'(bus.instr), 64'd0);
    check("mid_rst_ipc", 64'(bus.instr_pc), 64'd0);
    check("mid_rst_pc", 64'(pc), 64'd0);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("late_ack_req", 64'(bus.imem_req), 64'd0);
    check("late_ack_valid", 64'(bus.instr_valid), 64'd0);

    // PC wraps from the top of the address space.
    run_w = 1'b1;
    @(negedge clk);
    check("wrap_req", 64'(bus_w.imem_req), 64'd1);
    check("wrap_addr0", 64'(bus_w.imem_addr), 64'hFFFF_FFFC);
    bus_w.imem_ack   = 1'b1;
    bus_w.imem_rdata = word_of(32'hFFFF_FFFC);
    @(negedge clk);
    bus_w.imem_ack = 1'b0;
    check("wrap_valid", 64'(bus_w.instr_valid), 64'd1);
    check("wrap_instr", 64'(bus_w.instr), 64'(word_of(32'hFFFF_FFFC)));
    check("wrap_ipc", 64'(bus_w.instr_pc), 64'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_addr1", 64'(bus_w.imem_addr), 64'd0);
    check("wrap_pc", 64'(pc_w), 64'd0);
    run_w = 1'b0;
    @(negedge clk);

    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
